// File: rtl/out_bram_pkg.sv
// -----------------------------------------------------------------------------
// out_bram_pkg
//
// Shared definitions for the ping-pong output store:
//   - bank_state_e   : life cycle of one bank (FREE -> FILLING -> FULL -> FREE)
//   - DEF_*          : default geometry used as parameter defaults by the top
//   - ROWS_PER_BANK  : beats (rows) that fit in one bank at default geometry
//   - LANE_BITS      : bits needed to select one word within a beat
//   - rows_per_bank(): same quantity for an arbitrary geometry, so a top
//                      instantiated with non-default parameters stays consistent
// -----------------------------------------------------------------------------
package out_bram_pkg;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  localparam int unsigned DEF_ROWS           = 8;
  localparam int unsigned DEF_Y_BITS         = 32;
  localparam int unsigned DEF_OUT_ADDR_WIDTH = 10;
  localparam int unsigned DEF_OUT_BITS       = 32;

  localparam int unsigned ROWS_PER_BANK = (1 << DEF_OUT_ADDR_WIDTH) / DEF_ROWS;
  localparam int unsigned LANE_BITS     = $clog2(DEF_ROWS);

  function automatic int unsigned rows_per_bank(input int unsigned addr_w,
                                                input int unsigned rows);
    return (1 << addr_w) / rows;
  endfunction

endpackage

// File: rtl/out_bank_ram.sv
// -----------------------------------------------------------------------------
// out_bank_ram
//
// Simple dual-port RAM holding one bank of the ping-pong store. One full beat
// (all lanes) is written per cycle; reads return one full beat through an
// output register, so read data appears one cycle after the address.
// The memory array itself is never reset; only the read register is, so the
// store's read data is 0 out of reset.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (read register only)
//   we_i     in   write enable
//   waddr_i  in   write row
//   wdata_i  in   write beat
//   re_i     in   read enable; the read register holds when low
//   raddr_i  in   read row
//   rdata_o  out  registered read beat
// -----------------------------------------------------------------------------
module out_bank_ram #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-first: a read of the row being written this cycle returns the old row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/out_bram_pingpong.sv
// -----------------------------------------------------------------------------
// out_bram_pingpong
//
// Double-buffered output store. The engine streams one tile per packet into
// the current fill bank; a completed bank is offered to the processor
// (done_fill / done_words), which reads it word by word through a BRAM
// controller port and hands it back with a rising edge on t_done_proc.
//
// Ports:
//   aclk, aresetn       clock, asynchronous active-low reset
//   s_valid/s_ready     input beat handshake
//   s_data              ROWS words per beat, lane 0 in the low Y_BITS
//   s_last              last beat of a tile
//   bram_addr_a         byte address of the read word (bits [1:0] ignored)
//   bram_en_a           read enable (read data holds while low)
//   bram_rddata_a       read word, one cycle after address
//   done_fill           the read bank holds a completed tile
//   done_words          word count of that tile (0 while done_fill is low)
//   overflow            sticky: a tile ran past the end of a bank
//   t_done_proc         processor release, rising-edge sensitive
//   dbg_bank_state_o    state of both banks, index = bank number
//
// Handshake: a beat transfers on every rising clock edge where s_valid and
// s_ready are both high. s_ready is a function of registered state only
// (never of s_valid); the source must hold s_data/s_last stable while
// s_valid is high and s_ready is low.
// -----------------------------------------------------------------------------
module out_bram_pingpong
  import out_bram_pkg::*;
#(
  parameter int unsigned ROWS           = DEF_ROWS,
  parameter int unsigned Y_BITS         = DEF_Y_BITS,
  parameter int unsigned OUT_ADDR_WIDTH = DEF_OUT_ADDR_WIDTH,
  parameter int unsigned OUT_BITS       = DEF_OUT_BITS
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  output logic                        s_ready,
  input  logic                        s_valid,
  input  logic [ROWS*Y_BITS-1:0]      s_data,
  input  logic                        s_last,
  input  logic [OUT_ADDR_WIDTH+1:0]   bram_addr_a,
  input  logic                        bram_en_a,
  output logic [OUT_BITS-1:0]         bram_rddata_a,
  output logic                        done_fill,
  output logic [OUT_ADDR_WIDTH:0]     done_words,
  output logic                        overflow,
  input  logic                        t_done_proc,
  output bank_state_e [1:0]           dbg_bank_state_o
);

  localparam int unsigned RPB       = rows_per_bank(OUT_ADDR_WIDTH, ROWS);
  localparam int unsigned LB        = $clog2(ROWS);
  localparam int unsigned ROW_BITS  = OUT_ADDR_WIDTH - LB;
  localparam int unsigned BEAT_BITS = ROWS * Y_BITS;
  localparam int unsigned CNT_BITS  = OUT_ADDR_WIDTH + 1;

  // ---------------------------------------------------------------------------
  // Bank bookkeeping state
  // ---------------------------------------------------------------------------
  bank_state_e [1:0]              state_q, state_d;
  logic [1:0][CNT_BITS-1:0]       cnt_q, cnt_d;
  logic                           wr_bank_q, wr_bank_d;
  logic                           rd_bank_q, rd_bank_d;
  logic [ROW_BITS-1:0]            wr_row_q, wr_row_d;
  logic                           overflow_q, overflow_d;

  // Release edge detect: tdp_q is the sampled input, rel_pend_q marks a rise
  // seen at the previous edge; the release itself acts one edge later.
  logic                           tdp_q;
  logic                           rel_pend_q;

  logic                           ready_w;
  logic                           accept;
  logic                           row_last;
  logic                           close_tile;
  logic                           release_bank;
  logic [ROW_BITS:0]              rows_used;
  logic [CNT_BITS-1:0]            tile_words;

  always_comb begin
    ready_w      = (state_q[wr_bank_q] != BANK_FULL);
    accept       = s_valid && ready_w;
    row_last     = (wr_row_q == ROW_BITS'(RPB - 1));
    // The last row of a bank closes the tile even without s_last.
    close_tile   = accept && (s_last || row_last);
    release_bank = rel_pend_q && (state_q[rd_bank_q] == BANK_FULL);
    rows_used    = {1'b0, wr_row_q} + (ROW_BITS + 1)'(1);
    tile_words   = {rows_used, {LB{1'b0}}};

    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_row_d   = wr_row_q;
    overflow_d = overflow_q;

    // Release and write never touch the same bank in one cycle: release
    // needs the read bank FULL, a write needs the write bank not FULL.
    if (release_bank) begin
      state_d[rd_bank_q] = BANK_FREE;
      rd_bank_d          = ~rd_bank_q;
    end

    if (accept) begin
      state_d[wr_bank_q] = BANK_FILLING;
      wr_row_d           = wr_row_q + ROW_BITS'(1);
      if (close_tile) begin
        state_d[wr_bank_q] = BANK_FULL;
        cnt_d[wr_bank_q]   = tile_words;
        wr_bank_d          = ~wr_bank_q;
        wr_row_d           = '0;
        if (!s_last) begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= {BANK_FREE, BANK_FREE};
      cnt_q      <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_row_q   <= '0;
      overflow_q <= 1'b0;
      tdp_q      <= 1'b0;
      rel_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_row_q   <= wr_row_d;
      overflow_q <= overflow_d;
      tdp_q      <= t_done_proc;
      rel_pend_q <= t_done_proc && !tdp_q;
    end
  end

  assign s_ready          = ready_w;
  assign done_fill        = (state_q[rd_bank_q] == BANK_FULL);
  assign done_words       = done_fill ? cnt_q[rd_bank_q] : '0;
  assign overflow         = overflow_q;
  assign dbg_bank_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Bank RAMs. Both are read every enabled cycle; the bank that was the read
  // bank at address time is selected after the read register.
  // ---------------------------------------------------------------------------
  logic [ROW_BITS-1:0]  rd_row;
  logic [LB-1:0]        rd_lane;
  logic [BEAT_BITS-1:0] ram_rdata [2];

  assign rd_row  = bram_addr_a[OUT_ADDR_WIDTH+1 -: ROW_BITS];
  assign rd_lane = bram_addr_a[2 +: LB];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    out_bank_ram #(
      .WIDTH (BEAT_BITS),
      .DEPTH (RPB),
      .AW    (ROW_BITS)
    ) u_ram (
      .clk     (aclk),
      .rst_n   (aresetn),
      .we_i    (accept && (wr_bank_q == 1'(b))),
      .waddr_i (wr_row_q),
      .wdata_i (s_data),
      .re_i    (bram_en_a),
      .raddr_i (rd_row),
      .rdata_o (ram_rdata[b])
    );
  end

  // Bank select and lane index travel alongside the RAM read register so the
  // mux after it sees the values that belonged to the registered address.
  logic          rd_sel_q;
  logic [LB-1:0] lane_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_sel_q <= 1'b0;
      lane_q   <= '0;
    end else if (bram_en_a) begin
      rd_sel_q <= rd_bank_q;
      lane_q   <= rd_lane;
    end
  end

  logic [ROWS-1:0][Y_BITS-1:0] row_lanes;

  // Y_BITS and OUT_BITS are the same width by construction.
  assign row_lanes     = ram_rdata[rd_sel_q];
  assign bram_rddata_a = row_lanes[lane_q];

  // Byte-offset bits of the address carry no information for word reads.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bram_addr_a[1:0];

endmodule

// File: doc/out_bram_pingpong.md
# out_bram_pingpong

Double-buffered output store that sits directly downstream of the processing-engine output shifter. It accepts ROWS×Y_BITS AXI-stream beats, one packet per tile, into the current fill bank, and hands completed banks to the processor. The processor reads them word by word over a BRAM-controller port. Fill/drain is handshaken through `done_fill` and `t_done_proc`, so the engine can fill one bank while software drains the other.

## Interface
- `ROWS`, 8: words per input beat; power of two.
- `Y_BITS`, 32: bits per output word; must equal `OUT_BITS`.
- `OUT_ADDR_WIDTH`, 10: log2 of words per bank (1024 words).
- `OUT_BITS`, 32: read-port data width.

Ports:
- `aclk`, in, 1: clock.
- `aresetn`, in, 1: asynchronous active-low reset.
- `s_ready`, out, 1: beat acceptance.
- `s_valid`, in, 1: beat valid.
- `s_data`, in, ROWS*Y_BITS: beat payload; lane 0 is `[Y_BITS-1:0]`.
- `s_last`, in, 1: final beat of tile.
- `bram_addr_a`, in, OUT_ADDR_WIDTH+2: byte address; bits [1:0] ignored.
- `bram_en_a`, in, 1: read enable.
- `bram_rddata_a`, out, OUT_BITS: read data.
- `done_fill`, out, 1: a completed bank is available to read.
- `done_words`, out, OUT_ADDR_WIDTH+1: word count of the readable bank.
- `overflow`, out, 1: sticky; a tile exceeded bank capacity.
- `t_done_proc`, in, 1: processor release; rising-edge sensitive.

## Operation
- Two banks, each with state FREE, FILLING or FULL. Pointers: `wr_bank` and `rd_bank`, both reset to 0; `wr_row` resets to 0.
- Accept occurs when `s_valid && s_ready`. The beat is written to row `wr_row` of `wr_bank`, all ROWS lanes at once. Word index = `wr_row*ROWS + lane`. Bank state becomes FILLING. `wr_row` increments.
- Accept with `s_last`:
  - bank becomes FULL;
  - its word count `(wr_row+1)*ROWS` is latched per bank;
  - `wr_bank` toggles and `wr_row` clears to 0.
- Accept at `wr_row = 2^OUT_ADDR_WIDTH/ROWS - 1` without `s_last`: treated as `s_last` (bank closed, count = full bank), and `overflow` is set. It stays set until reset.
- `s_ready = (state[wr_bank] != FULL)`. When the next bank is still being read, input stalls until release.
- `done_fill = (state[rd_bank] == FULL)`. `done_words` = latched count of `rd_bank`; it is 0 when `done_fill` is low.
- `t_done_proc` is sampled into a register. A rising edge while `done_fill` is high sets `state[rd_bank]` to FREE and toggles `rd_bank`. A rising edge while `done_fill` is low is ignored.
- Reads always target `rd_bank`. Word index w = `bram_addr_a[OUT_ADDR_WIDTH+1:2]`; row = w/ROWS; lane = w%ROWS. Reading beyond `done_words`, or while `done_fill` is low, returns stale contents; no error is raised.
- Simultaneous events:
  - A release of bank X in the same cycle as `s_last` into bank Y: both take effect.
  - If Y was the bank being released, it is impossible, because a FULL bank is never written.
  - The bank freed this cycle is writable next cycle.

## Timing
- Reset values: `s_ready`=1, `done_fill`=0, `done_words`=0, `overflow`=0, `bram_rddata_a`=0. All bank states are FREE.
- Write is visible to reads 1 cycle after accept.
- `done_fill` rises the cycle after the `s_last` accept.
- Read latency is 1 cycle: `bram_rddata_a` is registered from the address presented with `bram_en_a` high, and holds when `bram_en_a` is low.
- Release: a `t_done_proc` rise seen at edge n causes `done_fill`/`rd_bank` to update after edge n+1 (registered edge detect).
- Throughput: 1 beat/cycle sustained while a bank is free; there is no bubble at a bank swap.
- `s_ready` does not depend combinationally on `s_valid`.
- Reset asserted mid-tile discards all bank contents and states. RAM contents themselves are not cleared.

## Structure
- Package `out_bram_pkg` holds:
  - bank-state enum (FREE, FILLING, FULL);
  - `ROWS_PER_BANK = 2**OUT_ADDR_WIDTH/ROWS`;
  - `LANE_BITS = $clog2(ROWS)`.
- Sub-module `out_bank_ram`, instantiated twice: ROWS*Y_BITS-wide simple dual-port RAM, depth ROWS_PER_BANK, one write port, one registered read port. The lane mux sits in the top level after the read register; the lane index is delayed 1 cycle to match.

## Test plan
- Tile of 3 beats, rows 0..2 with lane words `0x100*row+lane`, `s_last` on beat 2 -> `done_fill`=1 and `done_words`=24. Reading byte address 0x48 (word 18) returns 0x202.
- Two 1-beat tiles back to back, no release -> second tile fills bank 1, `s_ready` drops after its accept, and a third tile stalls. A `t_done_proc` pulse -> bank 0 freed, third tile accepted, `done_fill` stays 1 (bank 1 readable).
- 128 beats without `s_last` -> `overflow`=1 and `done_words`=1024. The next tile goes to the other bank.
- `t_done_proc` rising with `done_fill`=0 -> no state change. Holding `t_done_proc` high across two tiles -> only one release.
- `s_last` accept and release rising edge in the same cycle -> both banks update correctly, with no lost tile.
- Assert `aresetn`=0 mid-tile -> all outputs return to reset values. A fresh tile after release completes normally.
